system_qsys_nios2_qsys_oci_dct_packer: RTL and testbench

Producer end of the OCI debug-trace packing path. It accepts a stream of 2-bit compressed-trace symbols from the Nios II trace logic and packs up to 15 of them into a 30-bit DCT buffer with a 4-bit symbol count. It closes a frame when the buffer is full, on an explicit flush, or after an idle timeout. Each closed frame goes out through a one-deep valid/ready output register to the trace FIFO. The live `dct_buffer`/`dct_count` are exported for the OCI test bench monitor.

---
 rtl/system_qsys_nios2_qsys_oci_dct_packer.sv | 117 +++++++++++
 tb/tb_system_qsys_nios2_qsys_oci_dct_packer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_qsys_nios2_qsys_oci_dct_packer.sv
// OCI debug-trace packer: packs 2-bit trace symbols into 15-symbol DCT frames
// and hands each closed frame to the trace FIFO through a one-deep valid/ready slot.
module system_qsys_nios2_qsys_oci_dct_packer #(
  parameter int unsigned FLUSH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sym_valid,
  input  logic [1:0]  sym,
  input  logic        flush,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [33:0] frame_data,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        overflow,
  input  logic        ovf_clr
);

  localparam logic [15:0] TIMEOUT = 16'(FLUSH_TIMEOUT);
  localparam logic [3:0]  FULL    = 4'd15;

  typedef enum logic {
    S_FILL,
    S_PENDING
  } state_t;

  state_t      state, state_next;
  logic [15:0] idle_cnt;

  logic        slot_free;
  logic        accept;
  logic        drop;
  logic        timeout_hit;
  logic        close;
  logic        transfer;
  logic [3:0]  fill_count;
  logic [29:0] fill_buffer;
  logic [33:0] pack_data;

  // State register
  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FILL;
    else          state <= state_next;
  end

  // Next-state logic
  // NOTE: each combinational process assigns a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_FILL:    if (close && !slot_free) state_next = S_PENDING;
      S_PENDING: if (slot_free)           state_next = S_FILL;
      default:   state_next = S_FILL;
    endcase
  end

  // Output / datapath decode. While filling, the count never reaches 15 at rest
  // (a full buffer either transfers or parks in PENDING), so accept needs no full check.
  always_comb begin
    slot_free   = !frame_valid || frame_ready;
    accept      = sym_valid && (state == S_FILL);
    drop        = sym_valid && (state == S_PENDING);
    fill_count  = dct_count + {3'b000, accept};
    fill_buffer = dct_buffer;
    if (accept) fill_buffer = dct_buffer | (30'(sym) << {dct_count, 1'b0});
    timeout_hit = (TIMEOUT != 16'd0) && (idle_cnt == TIMEOUT) && (dct_count != 4'd0);
    close       = (state == S_FILL) &&
                  ((fill_count == FULL) || (flush && fill_count != 4'd0) || timeout_hit);
    transfer    = (close || (state == S_PENDING)) && slot_free;
    pack_data   = (state == S_FILL) ? {fill_count, fill_buffer} : {dct_count, dct_buffer};
  end

  // Packing buffer and output slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer  <= '0;
      dct_count   <= '0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
    end else if (transfer) begin
      frame_data  <= pack_data;
      frame_valid <= 1'b1;
      dct_buffer  <= '0;
      dct_count   <= '0;
    end else begin
      if (frame_ready) frame_valid <= 1'b0;
      // PENDING freezes the buffer; in FILL this also parks a closed frame.
      if (state == S_FILL) begin
        dct_buffer <= fill_buffer;
        dct_count  <= fill_count;
      end
    end
  end

  // Idle counter, saturating at the timeout so it never wraps past the trigger
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (transfer || accept || dct_count == 4'd0) begin
      idle_cnt <= '0;
    end else if (state == S_FILL && idle_cnt != TIMEOUT) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_system_qsys_nios2_qsys_oci_dct_packer.sv
// Self-checking bench for the DCT packer: scoreboard of expected frames plus
// directed checks on live buffer, handshake, overflow, timeout and reset.
module tb_system_qsys_nios2_qsys_oci_dct_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        sym_valid, flush, frame_ready, ovf_clr;
  logic [1:0]  sym;
  logic        frame_valid, overflow;
  logic [33:0] frame_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;

  logic        sv8, sv0;
  logic [1:0]  sym8, sym0;
  logic        fv8, fv0, ov8, ov0;
  logic [33:0] fd8, fd0;
  logic [29:0] db8, db0;
  logic [3:0]  dc8, dc0;
  logic        tie0 = 1'b0;
  logic        tie1 = 1'b1;

  system_qsys_nios2_qsys_oci_dct_packer u_dut (
    .clk(clk), .reset_n(reset_n), .sym_valid(sym_valid), .sym(sym), .flush(flush),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  system_qsys_nios2_qsys_oci_dct_packer #(.FLUSH_TIMEOUT(8)) u_dut_t8 (
    .clk(clk), .reset_n(reset_n), .sym_valid(sv8), .sym(sym8), .flush(tie0),
    .frame_valid(fv8), .frame_ready(tie1), .frame_data(fd8),
    .dct_buffer(db8), .dct_count(dc8), .overflow(ov8), .ovf_clr(tie0)
  );

  system_qsys_nios2_qsys_oci_dct_packer #(.FLUSH_TIMEOUT(0)) u_dut_t0 (
    .clk(clk), .reset_n(reset_n), .sym_valid(sv0), .sym(sym0), .flush(tie0),
    .frame_valid(fv0), .frame_ready(tie1), .frame_data(fd0),
    .dct_buffer(db0), .dct_count(dc0), .overflow(ov0), .ovf_clr(tie0)
  );

  int          errors = 0;
  int          checks = 0;
  logic [33:0] exp_q[$];
  logic [3:0]  m_cnt = 4'd0;
  logic [29:0] m_buf = 30'd0;

  // Reference packer model for the main DUT (no backpressure modelling)
  task automatic model_sym(input logic [1:0] s);
    m_buf = m_buf | (30'(s) << {m_cnt, 1'b0});
    m_cnt = m_cnt + 4'd1;
    if (m_cnt == 4'd15) begin
      exp_q.push_back({m_cnt, m_buf});
      m_cnt = 4'd0;
      m_buf = 30'd0;
    end
  endtask

  task automatic model_flush();
    if (m_cnt != 4'd0) begin
      exp_q.push_back({m_cnt, m_buf});
      m_cnt = 4'd0;
      m_buf = 30'd0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic fl);
    sym_valid = 1'b1;
    sym       = s;
    flush     = fl;
    model_sym(s);
    if (fl) model_flush();
    tick();
    sym_valid = 1'b0;
    flush     = 1'b0;
  endtask

  // Scoreboard monitor: compares each accepted frame and checks hold stability
  logic        holding = 1'b0;
  logic [33:0] hold_data;
  always @(negedge clk) begin
    logic [33:0] exp;
    if (!reset_n) begin
      holding = 1'b0;
    end else begin
      if (frame_valid && frame_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_unexpected: got %h, expected no frame", frame_data);
        end else begin
          exp = exp_q.pop_front();
          if (frame_data !== exp) begin
            errors++;
            $display("FAIL scoreboard_frame: got %h, expected %h", frame_data, exp);
          end
        end
      end
      if (holding && frame_valid) begin
        checks++;
        if (frame_data !== hold_data) begin
          errors++;
          $display("FAIL hold_stable: got %h, expected %h", frame_data, hold_data);
        end
      end
      holding   = frame_valid && !frame_ready;
      hold_data = frame_data;
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    sym_valid = 1'b0; sym = 2'b00; flush = 1'b0; frame_ready = 1'b0; ovf_clr = 1'b0;
    sv8 = 1'b0; sym8 = 2'b00; sv0 = 1'b0; sym0 = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if ({frame_valid, frame_data, dct_buffer, dct_count, overflow} !== 70'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h b=%h c=%0d o=%b, expected all zero",
               frame_valid, frame_data, dct_buffer, dct_count, overflow);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_full_frame();
    frame_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      send(2'b01, 1'b0);
      if (i == 2) begin
        checks++;
        if (dct_count !== 4'd3 || dct_buffer !== 30'h15) begin
          errors++;
          $display("FAIL live_buffer: got c=%0d b=%h, expected c=3 b=15", dct_count, dct_buffer);
        end
      end
      if (i == 13) begin
        checks++;
        if (frame_valid !== 1'b0) begin
          errors++;
          $display("FAIL early_frame: got valid=%b, expected 0", frame_valid);
        end
      end
    end
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== {4'd15, 30'h1555_5555} || dct_count !== 4'd0) begin
      errors++;
      $display("FAIL full_frame: got v=%b d=%h c=%0d, expected v=1 d=%h c=0",
               frame_valid, frame_data, dct_count, {4'd15, 30'h1555_5555});
    end
    tick();
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_frame_drop: got valid=%b, expected 0", frame_valid);
    end
  endtask

  task automatic test_partial_flush();
    send(2'b01, 1'b0);
    send(2'b10, 1'b0);
    send(2'b11, 1'b0);
    flush = 1'b1;
    model_flush();
    tick();
    flush = 1'b0;
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== 34'h0_C000_0039 || dct_buffer !== 30'd0) begin
      errors++;
      $display("FAIL partial_flush: got v=%b d=%h b=%h, expected v=1 d=0c0000039 b=0",
               frame_valid, frame_data, dct_buffer);
    end
    flush = 1'b1;
    model_flush();
    tick();
    flush = 1'b0;
    tick();
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_flush: got valid=%b, expected 0", frame_valid);
    end
  endtask

  task automatic test_flush_with_sym();
    send(2'b10, 1'b0);
    send(2'b01, 1'b0);
    send(2'b11, 1'b1);
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== 34'h0_C000_0036) begin
      errors++;
      $display("FAIL flush_with_sym: got v=%b d=%h, expected v=1 d=0c0000036",
               frame_valid, frame_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    frame_ready = 1'b1;
    for (int i = 0; i < 45; i++) send(2'($urandom_range(0, 3)), 1'b0);
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_drain: got %0d frames outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] first, second;
    frame_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(2'($urandom_range(0, 3)), 1'b0);
    first = frame_data;
    checks++;
    if (frame_valid !== 1'b1 || exp_q.size() == 0 || frame_data !== exp_q[0]) begin
      errors++;
      $display("FAIL bp_first_frame: got v=%b d=%h", frame_valid, frame_data);
    end
    for (int i = 0; i < 15; i++) send(2'($urandom_range(0, 3)), 1'b0);
    second = (exp_q.size() > 1) ? exp_q[1] : 34'd0;
    checks++;
    if (frame_data !== first || dct_count !== 4'd15 || dct_buffer !== second[29:0]) begin
      errors++;
      $display("FAIL bp_pending: got d=%h c=%0d b=%h, expected d=%h c=15 b=%h",
               frame_data, dct_count, dct_buffer, first, second[29:0]);
    end
    sym_valid = 1'b1; sym = 2'b11;
    tick();
    sym_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== second[29:0]) begin
      errors++;
      $display("FAIL bp_drop: got o=%b c=%0d b=%h, expected o=1 c=15 b=%h",
               overflow, dct_count, dct_buffer, second[29:0]);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (dct_count !== 4'd15 || frame_data !== first) begin
      errors++;
      $display("FAIL bp_flush_ignored: got c=%0d d=%h, expected c=15 d=%h",
               dct_count, frame_data, first);
    end
    frame_ready = 1'b1;
    tick();
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== second || dct_count !== 4'd0) begin
      errors++;
      $display("FAIL bp_second_frame: got v=%b d=%h c=%0d, expected v=1 d=%h c=0",
               frame_valid, frame_data, dct_count, second);
    end
    tick();
    checks++;
    if (frame_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got v=%b outstanding=%0d, expected v=0 outstanding=0",
               frame_valid, exp_q.size());
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got %b, expected 0", overflow);
    end
  endtask

  task automatic test_timeout();
    int          rise = 0;
    logic [33:0] cap = '0;
    sv8 = 1'b1; sym8 = 2'b10;
    tick();
    sv8 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (fv8 && rise == 0) begin
        rise = i;
        cap  = fd8;
      end
    end
    checks++;
    if (rise != 9 || cap !== 34'h0_4000_0002) begin
      errors++;
      $display("FAIL timeout_8: got rise=%0d d=%h, expected rise=9 d=040000002", rise, cap);
    end
    sv0 = 1'b1; sym0 = 2'b01;
    tick();
    sv0 = 1'b0;
    rise = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (fv0) rise = 1;
    end
    checks++;
    if (rise != 0 || dc0 !== 4'd1) begin
      errors++;
      $display("FAIL timeout_disabled: got frame_seen=%0d c=%0d, expected 0 and c=1", rise, dc0);
    end
  endtask

  task automatic test_reset_mid();
    frame_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(2'($urandom_range(0, 3)), 1'b0);
    for (int i = 0; i < 7; i++)  send(2'($urandom_range(0, 3)), 1'b0);
    checks++;
    if (frame_valid !== 1'b1 || dct_count !== 4'd7) begin
      errors++;
      $display("FAIL reset_mid_setup: got v=%b c=%0d, expected v=1 c=7", frame_valid, dct_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({frame_valid, frame_data, dct_buffer, dct_count, overflow} !== 70'd0) begin
      errors++;
      $display("FAIL reset_async: got v=%b d=%h b=%h c=%0d o=%b, expected all zero",
               frame_valid, frame_data, dct_buffer, dct_count, overflow);
    end
    exp_q.delete();
    m_cnt = 4'd0;
    m_buf = 30'd0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    frame_ready = 1'b1;
    for (int i = 0; i < 15; i++) send(2'($urandom_range(0, 3)), 1'b0);
    checks++;
    if (frame_valid !== 1'b1 || frame_data[33:30] !== 4'd15 || exp_q.size() == 0 ||
        frame_data !== exp_q[0]) begin
      errors++;
      $display("FAIL reset_recovery: got v=%b d=%h", frame_valid, frame_data);
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_partial_flush();
    test_flush_with_sym();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain: got %0d frames outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
